// File: rtl/fixed_sub_div_pkg.sv
// Shared constants and state encoding for the fixed-point subtract/divide block.
package fixed_pkg;

   localparam int DEF_DATA_WIDTH  = 16;
   localparam int DEF_FRACT_WIDTH = 8;

   // Saturation limits for the default Q8.8 format
   localparam logic [DEF_DATA_WIDTH-1:0] Q_MAX = {1'b0, {(DEF_DATA_WIDTH-1){1'b1}}};
   localparam logic [DEF_DATA_WIDTH-1:0] Q_MIN = {1'b1, {(DEF_DATA_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/udiv_restore_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module udiv_restore_step #(
   parameter int W = 16
) (
   input  logic [W-1:0] rem_in,
   input  logic         bit_in,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] rem_out,
   output logic         q_bit
);

   logic [W:0]   shifted;
   logic [W-1:0] trial;

   assign shifted = {rem_in, bit_in};
   // When the subtract succeeds the result is below the divisor, so W bits suffice
   assign trial   = shifted[W-1:0] - divisor;
   assign q_bit   = (shifted >= {1'b0, divisor});
   assign rem_out = q_bit ? trial : shifted[W-1:0];

endmodule

// File: rtl/fixed_sub_div.sv
// x = (y - b) / w0 in signed fixed point, one quotient bit per clock.
module fixed_sub_div
   import fixed_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int FRACT_WIDTH = DEF_FRACT_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] y,
   input  logic [DATA_WIDTH-1:0] w0,
   input  logic [DATA_WIDTH-1:0] b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] x,
   output logic                  sat,
   output logic                  div_zero
);

   localparam int QW = DATA_WIDTH + FRACT_WIDTH + 1;
   localparam int CW = $clog2(QW + 1);
   localparam logic [DATA_WIDTH-1:0] X_MAX   = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] X_MIN   = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [QW-1:0]         POS_LIM = QW'((1 << (DATA_WIDTH-1)) - 1);
   localparam logic [QW-1:0]         NEG_LIM = POS_LIM + 1'b1;

   div_state_t state, next_state;

   logic [CW-1:0]         count;
   logic [QW-1:0]         dividend;   // dividend bits shift out the top, quotient bits in the bottom
   logic [DATA_WIDTH-1:0] divisor;
   logic [DATA_WIDTH-1:0] rem;
   logic                  neg;

   logic                  accept, w_zero, last_step, handshake;
   logic [DATA_WIDTH:0]   diff, diff_mag;
   logic [DATA_WIDTH-1:0] w_mag, rem_next, x_res, x_dz;
   logic                  q_bit, sat_res;
   logic [QW-1:0]         q_final;
   logic                  in_ready_n, out_valid_n;

   assign accept    = in_valid && in_ready;
   assign handshake = out_valid && out_ready;
   assign w_zero    = (w0 == '0);
   assign last_step = (count == CW'(QW-1));

   // Sign-extended difference cannot overflow at DATA_WIDTH+1 bits
   assign diff     = {y[DATA_WIDTH-1], y} - {b[DATA_WIDTH-1], b};
   assign diff_mag = diff[DATA_WIDTH] ? -diff : diff;
   assign w_mag    = w0[DATA_WIDTH-1] ? -w0 : w0;
   assign x_dz     = (diff == '0) ? '0 : (diff[DATA_WIDTH] ? X_MIN : X_MAX);

   udiv_restore_step #(.W(DATA_WIDTH)) u_step (
      .rem_in  (rem),
      .bit_in  (dividend[QW-1]),
      .divisor (divisor),
      .rem_out (rem_next),
      .q_bit   (q_bit)
   );

   assign q_final = {dividend[QW-2:0], q_bit};

   // Apply sign and clamp the finished magnitude
   always_comb begin
      x_res   = neg ? -q_final[DATA_WIDTH-1:0] : q_final[DATA_WIDTH-1:0];
      sat_res = 1'b0;
      if (!neg && (q_final > POS_LIM)) begin
         x_res   = X_MAX;
         sat_res = 1'b1;
      end else if (neg && (q_final > NEG_LIM)) begin
         x_res   = X_MIN;
         sat_res = 1'b1;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = w_zero ? DONE : DIV;
         DIV:     if (last_step) next_state = DONE;
         DONE:    if (handshake) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Handshake outputs; out_valid trails DONE entry by one cycle
   always_comb begin
      in_ready_n  = (next_state == IDLE);
      out_valid_n = (state == DONE) && !handshake;
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         x         <= '0;
         sat       <= 1'b0;
         div_zero  <= 1'b0;
         count     <= '0;
         dividend  <= '0;
         divisor   <= '0;
         rem       <= '0;
         neg       <= 1'b0;
      end else begin
         in_ready  <= in_ready_n;
         out_valid <= out_valid_n;
         case (state)
            IDLE: if (accept) begin
               dividend <= {diff_mag, {FRACT_WIDTH{1'b0}}};
               divisor  <= w_mag;
               neg      <= diff[DATA_WIDTH] ^ w0[DATA_WIDTH-1];
               rem      <= '0;
               count    <= '0;
               if (w_zero) begin
                  x        <= x_dz;
                  sat      <= (diff != '0);
                  div_zero <= 1'b1;
               end
            end
            DIV: begin
               dividend <= q_final;
               rem      <= rem_next;
               count    <= count + 1'b1;
               if (last_step) begin
                  count <= '0;
                  x     <= x_res;
                  sat   <= sat_res;
               end
            end
            DONE: if (handshake) begin
               x        <= '0;
               sat      <= 1'b0;
               div_zero <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fixed_sub_div.sv
// Scoreboard bench for fixed_sub_div: integer reference model, randomized plus directed ops.
module tb_fixed_sub_div;
   import fixed_pkg::*;

   localparam int LAT_DIV = DEF_DATA_WIDTH + DEF_FRACT_WIDTH + 2;

   typedef struct {
      logic [15:0] x;
      logic        sat;
      logic        dz;
      int          lat;
      int          acc;
   } exp_t;

   logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready, sat, div_zero;
   logic [15:0] y, w0, b, x;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   bit   seen = 0;

   fixed_sub_div dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .y(y), .w0(w0), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .x(x), .sat(sat), .div_zero(div_zero)
   );

   initial clk = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Reference: real-valued (y-b)/w0 in Q8.8, truncated toward zero, clamped
   function automatic exp_t model(input logic [15:0] yv, input logic [15:0] wv, input logic [15:0] bv);
      exp_t   e;
      longint d, q;
      d = longint'($signed(yv)) - longint'($signed(bv));
      e.acc = 0;
      if (wv == 16'h0) begin
         e.dz = 1; e.lat = 1;
         if (d > 0)      begin e.x = Q_MAX; e.sat = 1; end
         else if (d < 0) begin e.x = Q_MIN; e.sat = 1; end
         else            begin e.x = 16'h0; e.sat = 0; end
      end else begin
         e.dz = 0; e.lat = LAT_DIV;
         q = (d * 256) / longint'($signed(wv));
         if (q > 32767)       begin e.x = Q_MAX; e.sat = 1; end
         else if (q < -32768) begin e.x = Q_MIN; e.sat = 1; end
         else                 begin e.x = q[15:0]; e.sat = 0; end
      end
      return e;
   endfunction

   task automatic issue(input logic [15:0] yv, input logic [15:0] wv, input logic [15:0] bv);
      exp_t e;
      int   n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin @(negedge clk); n++; end
      if (!in_ready) begin chk("in_ready_timeout", 0, 1); return; end
      in_valid = 1; y = yv; w0 = wv; b = bv;
      @(posedge clk); #1;
      e = model(yv, wv, bv);
      e.acc = cyc;
      exp_q.push_back(e);
      @(negedge clk);
      in_valid = 0; y = 16'($urandom); w0 = 16'($urandom); b = 16'($urandom);
   endtask

   task automatic collect(input int hold);
      int n = 0;
      while (!out_valid && n < 100) begin @(negedge clk); #1; n++; end
      if (!out_valid) begin chk("out_valid_timeout", 0, 1); return; end
      repeat (hold) @(negedge clk);
      @(negedge clk); out_ready = 1;
      @(negedge clk); out_ready = 0;
   endtask

   task automatic op(input logic [15:0] yv, input logic [15:0] wv, input logic [15:0] bv, input int hold);
      issue(yv, wv, bv);
      collect(hold);
   endtask

   // Monitor: latency on first out_valid, value compare on handshake
   initial begin
      forever begin
         @(negedge clk); #1;
         if (!rst_n) seen = 0;
         else begin
            if (out_valid && !seen) begin
               seen = 1;
               if (exp_q.size() == 0) chk("unexpected_out_valid", 1, 0);
               else chk("latency", cyc - exp_q[0].acc, exp_q[0].lat);
            end
            if (out_valid && out_ready && exp_q.size() != 0) begin
               chk("x", x, exp_q[0].x);
               chk("sat", sat, exp_q[0].sat);
               chk("div_zero", div_zero, exp_q[0].dz);
               void'(exp_q.pop_front());
               seen = 0;
            end
         end
      end
   end

   initial begin
      exp_t e;
      rst_n = 0; in_valid = 0; out_ready = 0; y = 0; w0 = 0; b = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_x", x, 0);
      chk("rst_sat", sat, 0);
      chk("rst_div_zero", div_zero, 0);
      @(negedge clk); rst_n = 1;
      @(posedge clk); #1;
      chk("in_ready_after_reset", in_ready, 1);

      // Directed plan items
      op(16'h0300, 16'h0080, 16'h0100, 0);
      op(16'h0100, 16'h0200, 16'h0300, 1);
      op(16'h0100, 16'h0300, 16'h0000, 0);
      op(16'h0100, 16'hFD00, 16'h0000, 2);
      op(16'h7F00, 16'h0001, 16'h8100, 0);
      op(16'h7F00, 16'hFFFF, 16'h8100, 0);
      op(16'h0100, 16'h0000, 16'h0000, 0);
      op(16'h0100, 16'h0000, 16'h0100, 1);
      op(16'h0000, 16'h0000, 16'h0100, 0);
      op(16'h8000, 16'h0100, 16'h0000, 0);  // exactly min negative, not saturated

      // Backpressure: hold DONE, new in_valid must be ignored
      issue(16'h0300, 16'h0080, 16'h0100);
      e = exp_q[0];
      for (int n = 0; n < 100 && !out_valid; n++) begin @(negedge clk); #1; end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1; y = 16'($urandom); w0 = 16'($urandom); b = 16'($urandom);
         #1;
         chk("bp_out_valid", out_valid, 1);
         chk("bp_x", x, e.x);
         chk("bp_flags", {sat, div_zero}, {e.sat, e.dz});
         chk("bp_in_ready", in_ready, 0);
      end
      @(negedge clk); in_valid = 0; out_ready = 1;
      @(posedge clk); #1;
      chk("post_hs_x", x, 0);
      chk("post_hs_out_valid", out_valid, 0);
      chk("post_hs_in_ready", in_ready, 1);
      @(negedge clk); out_ready = 0;

      // Reset in the middle of DIV
      issue(16'h0300, 16'h0080, 16'h0100);
      repeat (9) @(posedge clk);
      #2 rst_n = 0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_x", x, 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1;
      @(posedge clk); #1;
      chk("midrst_in_ready_rise", in_ready, 1);
      op(16'h0300, 16'h0080, 16'h0100, 0);

      // Randomized operations
      for (int i = 0; i < 40; i++) begin
         logic [15:0] ry, rw, rb;
         ry = 16'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? ry : 16'($urandom);
         case ($urandom_range(0, 7))
            0:       rw = 16'h0000;
            1:       rw = 16'($urandom_range(1, 15));
            2:       rw = 16'h8000;
            3:       rw = 16'hFFFF - 16'($urandom_range(0, 15));
            default: rw = 16'($urandom);
         endcase
         op(ry, rw, rb, $urandom_range(0, 2));
      end

      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) chk("leftover_expected", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
